fx1_pipe: RTL
=============

FX1_PIPE -- requirements
Module: fx1_pipe

Interface
REQ-001 Parameter DATA_W, default 128: register operand width; SHALL be a multiple of 32.
REQ-002 Parameter STAGES, default 2: result latency in cycles, legal range 1..8.
REQ-003 Parameter TAG_W, default 7: destination register address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  issue strobe; one instruction accepted per cycle, no backpressure.
REQ-007 instr_id  in  7  instruction ID from the shared opcode package.
REQ-008 ra, rb, rc  in  DATA_W each  source operands; rc carries rt data for selb/iohl.
REQ-009 imme  in  18  raw immediate field; decode selects the 10-, 16- or 18-bit slice.
REQ-010 rt_addr  in  TAG_W  destination register tag.
REQ-011 flush  in  1  kill all in-flight instructions, including a same-cycle issue.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_wr_en  out  1  register-file write enable; out_valid AND recognised instr_id.
REQ-014 out_rt_addr  out  TAG_W  tag of the result.
REQ-015 result  out  DATA_W  computed value.

Function
REQ-016 Supported IDs: a, ah, ai, ahi, sf, sfh, sfi, and, andi, or, ori, xor, xori, nand, nor, eqv, ceq, ceqh, ceqi, cgt, cgth, cgti, clz, il, ilh, ilhu, ila, iohl, selb.
REQ-017 Word ops SHALL operate independently on each 32-bit slot, halfword ops on each 16-bit slot; carries SHALL NOT cross slots; sums wrap modulo 2^32 or 2^16.
REQ-018 Halfword/word immediates SHALL be sign-extended; ila SHALL zero-extend 18 bits; il SHALL sign-extend 16 bits.
REQ-019 Compares SHALL produce all-ones or all-zeros per slot; cgt compares signed.
REQ-020 clz SHALL return 32 for a zero word.
REQ-021 Computation SHALL be registered in stage 1; stages 2..STAGES SHALL be pure delay registers.
REQ-022 An instruction issued in cycle N SHALL appear on outputs in cycle N+STAGES.
REQ-023 Back-to-back issue SHALL produce back-to-back results in issue order.
REQ-024 Unrecognised instr_id: out_valid=1, out_wr_en=0, result=0.
REQ-025 flush SHALL clear the valid bit of every stage in the same edge; data registers may hold stale values.
REQ-026 A flushed stage SHALL NOT update data registers (no spurious toggling).

Reset
REQ-027 While reset is high: all stage valid bits, out_valid, out_wr_en = 0; result = 0; out_rt_addr = 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight instructions; the first issue after deassertion behaves per REQ-022.

Configuration
REQ-029 Macro FX1_PIPE_FWD_EN defined: add outputs fwd_valid[STAGES], fwd_rt[STAGES*TAG_W], fwd_data[STAGES*DATA_W] exposing each stage's valid, tag and value for bypass.
REQ-030 Macro undefined: the ports SHALL be absent; the functional behaviour is identical.

Structure
REQ-031 Instruction IDs, slot widths and the STAGES range limit SHALL live in the shared SPU package.
REQ-032 Per-32-bit-slot arithmetic SHALL be one sub-module fx1_slot_alu, instantiated DATA_W/32 times.

Verification
REQ-033 a with ra=0x7FFFFFFF and rb=1 in all slots -> 0x80000000 per slot at cycle N+2; no carry into the adjacent slot.
REQ-034 ahi with ra halfwords=0x0001 and imme10=0x3FF (-1) -> 0x0000 in every halfword.
REQ-035 Issue 5 consecutive ops with tags 1..5 and STAGES=3 -> tags 1..5 emerge on 5 consecutive cycles.
REQ-036 Issue at N and N+1, flush at N+1 -> no out_valid at N+2 or N+3.
REQ-037 Reset pulse while 2 ops are in flight -> out_valid stays 0; the next op after release returns after exactly STAGES cycles.
REQ-038 clz with ra word 0x00000000 returns 32; instr_id 0x7F -> out_valid=1, out_wr_en=0, result=0.

Source files
------------

// File: rtl/fx1_pipe_pkg.sv
// Shared SPU definitions for the fixed-point FX1 pipe: instruction IDs, slot widths,
// pipeline depth limits and small per-slot helper functions.
package fx1_pipe_pkg;

    localparam int SLOT_W     = 32;
    localparam int HALF_W     = 16;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;

    // IDs are contiguous so that recognition is a single range check.
    typedef enum logic [6:0] {
        ID_A    = 7'd1,  ID_AH   = 7'd2,  ID_AI   = 7'd3,  ID_AHI  = 7'd4,
        ID_SF   = 7'd5,  ID_SFH  = 7'd6,  ID_SFI  = 7'd7,  ID_AND  = 7'd8,
        ID_ANDI = 7'd9,  ID_OR   = 7'd10, ID_ORI  = 7'd11, ID_XOR  = 7'd12,
        ID_XORI = 7'd13, ID_NAND = 7'd14, ID_NOR  = 7'd15, ID_EQV  = 7'd16,
        ID_CEQ  = 7'd17, ID_CEQH = 7'd18, ID_CEQI = 7'd19, ID_CGT  = 7'd20,
        ID_CGTH = 7'd21, ID_CGTI = 7'd22, ID_CLZ  = 7'd23, ID_IL   = 7'd24,
        ID_ILH  = 7'd25, ID_ILHU = 7'd26, ID_ILA  = 7'd27, ID_IOHL = 7'd28,
        ID_SELB = 7'd29
    } fx1_id_e;

    function automatic logic is_supported(input logic [6:0] id);
        return (id >= 7'(ID_A)) && (id <= 7'(ID_SELB));
    endfunction

    function automatic logic [5:0] clz32(input logic [31:0] w);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    function automatic logic [31:0] hw_add(input logic [31:0] a, input logic [31:0] b);
        return {a[31:16] + b[31:16], a[15:0] + b[15:0]};
    endfunction

    function automatic logic [31:0] hw_sub(input logic [31:0] a, input logic [31:0] b);
        return {a[31:16] - b[31:16], a[15:0] - b[15:0]};
    endfunction

    function automatic logic [31:0] hw_ceq(input logic [31:0] a, input logic [31:0] b);
        return {{16{a[31:16] == b[31:16]}}, {16{a[15:0] == b[15:0]}}};
    endfunction

    function automatic logic [31:0] hw_cgt(input logic [31:0] a, input logic [31:0] b);
        return {{16{$signed(a[31:16]) > $signed(b[31:16])}},
                {16{$signed(a[15:0]) > $signed(b[15:0])}}};
    endfunction

endpackage

// File: rtl/fx1_slot_alu.sv
// One 32-bit slot of the FX1 datapath; halfword ops work on the two 16-bit halves
// of the slot, so no carry ever leaves the slot. Subtracts compute rb - ra.
module fx1_slot_alu
    import fx1_pipe_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    input  logic [31:0] rc,
    input  logic [17:0] imme,
    output logic [31:0] res
);

    logic [31:0] i10_w;
    logic [15:0] i10_h;
    logic [31:0] i16_w;

    assign i10_w = {{22{imme[9]}}, imme[9:0]};
    assign i10_h = {{6{imme[9]}}, imme[9:0]};
    assign i16_w = {{16{imme[15]}}, imme[15:0]};

    always_comb begin
        res = '0;
        case (op)
            ID_A:    res = ra + rb;
            ID_AH:   res = hw_add(ra, rb);
            ID_AI:   res = ra + i10_w;
            ID_AHI:  res = hw_add(ra, {i10_h, i10_h});
            ID_SF:   res = rb - ra;
            ID_SFH:  res = hw_sub(rb, ra);
            ID_SFI:  res = i10_w - ra;
            ID_AND:  res = ra & rb;
            ID_ANDI: res = ra & i10_w;
            ID_OR:   res = ra | rb;
            ID_ORI:  res = ra | i10_w;
            ID_XOR:  res = ra ^ rb;
            ID_XORI: res = ra ^ i10_w;
            ID_NAND: res = ~(ra & rb);
            ID_NOR:  res = ~(ra | rb);
            ID_EQV:  res = ~(ra ^ rb);
            ID_CEQ:  res = {32{ra == rb}};
            ID_CEQH: res = hw_ceq(ra, rb);
            ID_CEQI: res = {32{ra == i10_w}};
            ID_CGT:  res = {32{$signed(ra) > $signed(rb)}};
            ID_CGTH: res = hw_cgt(ra, rb);
            ID_CGTI: res = {32{$signed(ra) > $signed(i10_w)}};
            ID_CLZ:  res = {26'd0, clz32(ra)};
            ID_IL:   res = i16_w;
            ID_ILH:  res = {imme[15:0], imme[15:0]};
            ID_ILHU: res = {imme[15:0], 16'd0};
            ID_ILA:  res = {14'd0, imme};
            // rc carries the old destination value (iohl) or the select mask (selb)
            ID_IOHL: res = rc | {16'd0, imme[15:0]};
            ID_SELB: res = (ra & ~rc) | (rb & rc);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/fx1_pipe.sv
// FX1 fixed-point pipe: compute in stage 1, pure delay in stages 2..STAGES.
// Define FX1_PIPE_FWD_EN to expose per-stage valid/tag/data bypass ports.
module fx1_pipe
    import fx1_pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int STAGES = 2,
    parameter int TAG_W  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [6:0]          instr_id,
    input  logic [DATA_W-1:0]   ra,
    input  logic [DATA_W-1:0]   rb,
    input  logic [DATA_W-1:0]   rc,
    input  logic [17:0]         imme,
    input  logic [TAG_W-1:0]    rt_addr,
    input  logic                flush,
    output logic                out_valid,
    output logic                out_wr_en,
    output logic [TAG_W-1:0]    out_rt_addr,
    output logic [DATA_W-1:0]   result
`ifdef FX1_PIPE_FWD_EN
    ,
    output logic [STAGES-1:0]        fwd_valid,
    output logic [STAGES*TAG_W-1:0]  fwd_rt,
    output logic [STAGES*DATA_W-1:0] fwd_data
`endif
);

    localparam int NSLOT = DATA_W / SLOT_W;

    logic [DATA_W-1:0] alu_res;
    logic              instr_known;

    logic              valid_q [STAGES];
    logic              valid_d [STAGES];
    logic              wr_q    [STAGES];
    logic              wr_d    [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_d   [STAGES];
    logic [DATA_W-1:0] data_q  [STAGES];
    logic [DATA_W-1:0] data_d  [STAGES];

    assign instr_known = is_supported(instr_id);

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            fx1_slot_alu u_alu (
                .op   (instr_id),
                .ra   (ra[gi*SLOT_W +: SLOT_W]),
                .rb   (rb[gi*SLOT_W +: SLOT_W]),
                .rc   (rc[gi*SLOT_W +: SLOT_W]),
                .imme (imme),
                .res  (alu_res[gi*SLOT_W +: SLOT_W])
            );
        end
    endgenerate

    // Data/tag registers only load behind a surviving valid, so flushed or idle
    // stages keep their old contents instead of toggling.
    always_comb begin
        valid_d = '{default: 1'b0};
        wr_d    = wr_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (!flush) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                wr_d[0]   = instr_known;
                tag_d[0]  = rt_addr;
                data_d[0] = instr_known ? alu_res : '0;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    wr_d[s]   = wr_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                    data_d[s] = data_q[s-1];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                    wr_q[gi]    <= 1'b0;
                    tag_q[gi]   <= '0;
                    data_q[gi]  <= '0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    wr_q[gi]    <= wr_d[gi];
                    tag_q[gi]   <= tag_d[gi];
                    data_q[gi]  <= data_d[gi];
                end
            end
        end
    endgenerate

    assign out_valid   = valid_q[STAGES-1];
    assign out_wr_en   = valid_q[STAGES-1] & wr_q[STAGES-1];
    assign out_rt_addr = tag_q[STAGES-1];
    assign result      = data_q[STAGES-1];

`ifdef FX1_PIPE_FWD_EN
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_fwd
            assign fwd_valid[gi]                       = valid_q[gi];
            assign fwd_rt[gi*TAG_W +: TAG_W]           = tag_q[gi];
            assign fwd_data[gi*DATA_W +: DATA_W]       = data_q[gi];
        end
    endgenerate
`endif

endmodule
